// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_pkg
// Brief    : Shared constants and state encoding for the sound command path.
// Revision : 1.0
// ============================================================================
package sound_pkg;

  localparam int CMD_W = 6;
  localparam logic [CMD_W-1:0] SND_IDLE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sound_req_slot.sv
`default_nettype none
// ============================================================================
// Module   : sound_req_slot
// Brief    : One pending command slot; a new request wins over a same-cycle
//            grant and flags an overwrite of an ungranted command.
// Revision : 1.0
// ============================================================================
module sound_req_slot
  import sound_pkg::*;
(
  input  logic             clk_4e,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             grant,
  output logic             valid,
  output logic [CMD_W-1:0] cmd,
  output logic             ovf
);

  logic             r_valid;
  logic [CMD_W-1:0] r_cmd;
  logic             r_ovf;

  always_ff @(posedge clk_4e or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cmd   <= SND_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (req) begin
        r_valid <= 1'b1;
        r_cmd   <= cmd_in;
        // A command being granted this cycle is not lost, so it is no overwrite.
        r_ovf   <= r_valid && !grant;
      end else if (grant) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid = r_valid;
  assign cmd   = r_cmd;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sound_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : sound_cmd_sched
// Brief    : Fixed-priority scheduler driving the sound board pb/hand bus with
//            a fixed hold window and idle gap per command.
// Revision : 1.0
// ============================================================================
module sound_cmd_sched
  import sound_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                  clk_4e,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [CMD_W*NREQ-1:0] cmd,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       ovf,
  output logic [CMD_W-1:0]      pb,
  output logic                  hand,
  output logic                  busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_4e or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [NREQ-1:0]  w_valid;
  logic [CMD_W-1:0] w_slot_cmd [NREQ];
  logic [NREQ-1:0]  w_take;
  logic [CMD_W-1:0] w_grant_cmd;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0]  r_ack;
  logic [CMD_W-1:0] r_pb;
  logic             r_hand;
  logic             r_busy;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    sound_req_slot u_slot (
      .clk_4e (clk_4e),
      .rst_n  (w_rst_n),
      .req    (req[gi]),
      .cmd_in (cmd[CMD_W*gi +: CMD_W]),
      .grant  (w_take[gi]),
      .valid  (w_valid[gi]),
      .cmd    (w_slot_cmd[gi]),
      .ovf    (ovf[gi])
    );
  end

  // Lowest pending index wins, and only while the bus is idle.
  always_comb begin
    logic w_found;
    w_found     = 1'b0;
    w_take      = '0;
    w_grant_cmd = SND_IDLE;
    for (int i = 0; i < NREQ; i++) begin
      if (w_valid[i] && !w_found && r_state == IDLE) begin
        w_found     = 1'b1;
        w_take[i]   = 1'b1;
        w_grant_cmd = w_slot_cmd[i];
      end
    end
  end

  always_ff @(posedge clk_4e or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_pb    <= SND_IDLE;
      r_hand  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= w_take;
      case (r_state)
        IDLE: begin
          // Granting an idle-valued command acknowledges it without touching the bus.
          if ((|w_take) && (w_grant_cmd != SND_IDLE)) begin
            r_pb    <= w_grant_cmd;
            r_hand  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            r_pb    <= SND_IDLE;
            r_hand  <= 1'b0;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack  = r_ack;
  assign pb   = r_pb;
  assign hand = r_hand;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sound_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_cmd_sched
// Brief    : Directed self-checking bench for sound_cmd_sched.
// Revision : 1.0
// ============================================================================
module tb_sound_cmd_sched;

  localparam int NREQ = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;

  logic              clk_4e = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [6*NREQ-1:0] cmd;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   ovf;
  logic [5:0]        pb;
  logic              hand;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;

  sound_cmd_sched #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk_4e (clk_4e),
    .rst_n  (rst_n),
    .req    (req),
    .cmd    (cmd),
    .ack    (ack),
    .ovf    (ovf),
    .pb     (pb),
    .hand   (hand),
    .busy   (busy)
  );

  always #5 clk_4e = ~clk_4e;

  typedef struct {
    int         idx;
    logic [5:0] c;
    logic [3:0] exp_ack;
    logic [5:0] exp_pb;
    logic       exp_hand;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk_4e);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [5:0] c);
    req[idx]        = 1'b1;
    cmd[idx*6 +: 6] = c;
  endtask

  // Called right after the grant edge; follows one full DRIVE and GAP period.
  task automatic expect_drive(input logic [3:0] ack_e, input logic [5:0] pb_e);
    check("grant_ack", 32'(ack), 32'(ack_e));
    check("grant_pb", 32'(pb), 32'(pb_e));
    check("grant_hand", 32'(hand), 32'd1);
    check("grant_busy", 32'(busy), 32'd1);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check("hold_pb", 32'(pb), 32'(pb_e));
      check("hold_hand", 32'(hand), 32'd1);
      check("hold_ack", 32'(ack), 32'd0);
    end
    for (int k = 0; k < GAP; k++) begin
      tick();
      check("gap_pb", 32'(pb), 32'h3F);
      check("gap_hand", 32'(hand), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_ack", 32'(ack), 32'd0);
    end
    tick();
    check("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int seen_hand;
    int seen_ack;

    vecs[0] = '{idx: 2, c: 6'h05, exp_ack: 4'b0100, exp_pb: 6'h05, exp_hand: 1'b1};
    vecs[1] = '{idx: 1, c: 6'h3F, exp_ack: 4'b0010, exp_pb: 6'h3F, exp_hand: 1'b0};
    vecs[2] = '{idx: 3, c: 6'h2A, exp_ack: 4'b1000, exp_pb: 6'h2A, exp_hand: 1'b1};
    vecs[3] = '{idx: 0, c: 6'h00, exp_ack: 4'b0001, exp_pb: 6'h00, exp_hand: 1'b1};

    rst_n = 1'b0;
    req   = '0;
    cmd   = '0;
    tick();
    tick();
    check("rst_pb", 32'(pb), 32'h3F);
    check("rst_hand", 32'(hand), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    // Single requests, including the idle-valued no-op command.
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].idx, vecs[v].c);
      tick();
      req = '0;
      check("vec_no_early_ack", 32'(ack), 32'd0);
      tick();
      if (vecs[v].exp_hand) begin
        expect_drive(vecs[v].exp_ack, vecs[v].exp_pb);
      end else begin
        check("noop_ack", 32'(ack), 32'(vecs[v].exp_ack));
        check("noop_hand", 32'(hand), 32'd0);
        check("noop_busy", 32'(busy), 32'd0);
        check("noop_pb", 32'(pb), 32'h3F);
        tick();
        check("noop_ack_clear", 32'(ack), 32'd0);
        check("noop_busy_after", 32'(busy), 32'd0);
        check("noop_hand_after", 32'(hand), 32'd0);
      end
    end

    // Priority: lower index first, next grant exactly HOLD+GAP+1 cycles later.
    set_req(3, 6'h11);
    set_req(1, 6'h22);
    tick();
    req = '0;
    tick();
    expect_drive(4'b0010, 6'h22);
    tick();
    expect_drive(4'b1000, 6'h11);

    // Overwrite of an ungranted command during another requester's DRIVE.
    set_req(2, 6'h05);
    tick();
    req = '0;
    tick();
    check("ovw_first_ack", 32'(ack), 32'b0100);
    tick();
    set_req(0, 6'h0A);
    tick();
    req = '0;
    check("ovw_first_no_ovf", 32'(ovf), 32'd0);
    tick();
    set_req(0, 6'h0B);
    tick();
    req = '0;
    check("ovw_ovf_pulse", 32'(ovf), 32'b0001);
    check("ovw_pb_held", 32'(pb), 32'h05);
    tick();
    check("ovw_ovf_once", 32'(ovf), 32'd0);
    wait_idle(HOLD + GAP + 4);
    tick();
    expect_drive(4'b0001, 6'h0B);
    tick();
    check("ovw_no_stale", 32'(ack), 32'd0);
    check("ovw_no_stale_hand", 32'(hand), 32'd0);

    // Grant collision: a new request on the grant edge survives without ovf.
    set_req(0, 6'h12);
    tick();
    set_req(0, 6'h13);
    tick();
    req = '0;
    check("coll_ovf", 32'(ovf), 32'd0);
    expect_drive(4'b0001, 6'h12);
    tick();
    expect_drive(4'b0001, 6'h13);

    // Reset during DRIVE clears outputs at once and discards pending slots.
    set_req(1, 6'h07);
    set_req(3, 6'h09);
    tick();
    req = '0;
    tick();
    check("rmid_grant", 32'(ack), 32'b0010);
    for (int k = 0; k < 4; k++) tick();
    check("rmid_hand_before", 32'(hand), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_pb", 32'(pb), 32'h3F);
    check("rmid_hand", 32'(hand), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ack", 32'(ack), 32'd0);
    tick();
    rst_n = 1'b1;
    seen_hand = 0;
    seen_ack  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hand === 1'b1) seen_hand++;
      if (ack !== '0) seen_ack++;
    end
    check("rmid_lost_hand", 32'(seen_hand), 32'd0);
    check("rmid_lost_ack", 32'(seen_ack), 32'd0);

    do_reset();
    set_req(2, 6'h15);
    tick();
    req = '0;
    tick();
    expect_drive(4'b0100, 6'h15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
